// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M in the Montgomery
// domain by driving one external mon_prod instance, then converting the result back out.
module mod_exp_ctrl #(
   parameter int bitLen     = 64,
   parameter int countWidth = 5,
   parameter int expLen     = 64,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [bitLen-1:0]     M,
   input  logic [expLen-1:0]     E,
   input  logic [bitLen-1:0]     X_bar,
   input  logic [bitLen-1:0]     R_mod,
   input  logic [countWidth-1:0] num_words,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [bitLen-1:0]     result,
   output logic                  mp_start,
   output logic [bitLen-1:0]     mp_A,
   output logic [bitLen-1:0]     mp_B,
   output logic [bitLen-1:0]     mp_M,
   output logic [countWidth-1:0] mp_num_words,
   input  logic                  mp_stop,
   input  logic [bitLen:0]       mp_P
);

   localparam int IDX_W = (expLen > 1) ? $clog2(expLen) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SCAN    = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_GAP     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OP_SQ   = 2'd0,
      OP_MUL  = 2'd1,
      OP_CONV = 2'd2
   } op_t;

   state_t             state_r, state_next_s;
   op_t                op_r, op_next_s;
   logic [IDX_W-1:0]   idx_r, idx_next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [bitLen-1:0]  m_r, xbar_r, acc_r;
   logic [expLen-1:0]  e_r;
   logic [countWidth-1:0] nw_r;
   logic [bitLen-1:0]  reduced_s, operand_b_s;
   logic               timeout_s, bit_s;

   // Final Montgomery correction: mon_prod output is < 2M, so one subtraction suffices.
   function automatic logic [bitLen-1:0] cond_sub(input logic [bitLen:0] p, input logic [bitLen-1:0] m);
      logic [bitLen:0] diff;
      diff = p - {1'b0, m};
      if (p >= {1'b0, m}) begin
         cond_sub = diff[bitLen-1:0];
      end else begin
         cond_sub = p[bitLen-1:0];
      end
   endfunction

   // Datapath helpers shared by the next-state and output processes.
   always_comb begin
      reduced_s = cond_sub(mp_P, m_r);
      timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
      bit_s     = e_r[idx_r];
      case (op_r)
         OP_SQ:   operand_b_s = acc_r;
         OP_MUL:  operand_b_s = xbar_r;
         OP_CONV: operand_b_s = {{(bitLen-1){1'b0}}, 1'b1};
         default: operand_b_s = {{(bitLen-1){1'b0}}, 1'b1};
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic, including which product comes next and the exponent bit index.
   always_comb begin
      state_next_s = state_r;
      op_next_s    = op_r;
      idx_next_s   = idx_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_next_s = S_SCAN;
               idx_next_s   = IDX_W'(expLen - 1);
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_SCAN: begin
            if (e_r == {expLen{1'b0}}) begin
               op_next_s    = OP_CONV;
               state_next_s = S_ISSUE;
            end else if (bit_s) begin
               op_next_s    = OP_SQ;
               state_next_s = S_ISSUE;
            end else begin
               idx_next_s   = idx_r - IDX_W'(1);
            end
         end
         S_ISSUE: begin
            if (!mp_stop) begin
               state_next_s = S_WAIT;
            end else begin
               state_next_s = S_ISSUE;
            end
         end
         S_WAIT: begin
            // A completion in the terminal-count cycle still counts as success.
            if (mp_stop) begin
               state_next_s = S_CAPTURE;
            end else if (timeout_s) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_WAIT;
            end
         end
         S_CAPTURE: begin
            if (op_r == OP_CONV) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_GAP;
            end
         end
         S_GAP: begin
            state_next_s = S_ISSUE;
            if ((op_r == OP_SQ) && bit_s) begin
               op_next_s = OP_MUL;
            end else if (idx_r == {IDX_W{1'b0}}) begin
               op_next_s = OP_CONV;
            end else begin
               op_next_s  = OP_SQ;
               idx_next_s = idx_r - IDX_W'(1);
            end
         end
         S_DONE:  state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // Registered outputs and datapath, all derived from the upcoming state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r         <= OP_SQ;
         idx_r        <= {IDX_W{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         m_r          <= {bitLen{1'b0}};
         e_r          <= {expLen{1'b0}};
         xbar_r       <= {bitLen{1'b0}};
         nw_r         <= {countWidth{1'b0}};
         acc_r        <= {bitLen{1'b0}};
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         result       <= {bitLen{1'b0}};
         mp_start     <= 1'b0;
         mp_A         <= {bitLen{1'b0}};
         mp_B         <= {bitLen{1'b0}};
         mp_M         <= {bitLen{1'b0}};
         mp_num_words <= {countWidth{1'b0}};
      end else begin
         op_r     <= op_next_s;
         idx_r    <= idx_next_s;
         busy     <= (state_next_s != S_IDLE) && (state_next_s != S_DONE);
         done     <= (state_next_s == S_DONE);
         mp_start <= (state_next_s == S_WAIT);
         if ((state_r == S_IDLE) && start) begin
            m_r    <= M;
            e_r    <= E;
            xbar_r <= X_bar;
            nw_r   <= num_words;
            acc_r  <= R_mod;
            err    <= 1'b0;
         end
         if ((state_r == S_ISSUE) && !mp_stop) begin
            mp_A         <= acc_r;
            mp_B         <= operand_b_s;
            mp_M         <= m_r;
            mp_num_words <= nw_r;
            cnt_r        <= {CNT_W{1'b0}};
         end else if (state_r == S_WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         // Product is taken as soon as mp_stop is seen, while mp_P is known valid.
         if ((state_r == S_WAIT) && mp_stop) begin
            acc_r <= reduced_s;
            if (op_r == OP_CONV) begin
               result <= reduced_s;
            end
         end else if ((state_r == S_WAIT) && timeout_s) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: behavioural mon_prod stub, vector table and
// scoreboard, plus hand-written timeout, reset and DONE-cycle sequences.
module tb_mod_exp_ctrl;

   localparam logic [63:0] M_MOD = 64'd311;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] M = 64'd0, E = 64'd0, X_bar = 64'd0, R_mod = 64'd0;
   logic [4:0]  num_words = 5'd0;
   logic        busy, done, err, mp_start, mp_stop;
   logic [63:0] result, mp_A, mp_B, mp_M;
   logic [4:0]  mp_num_words;
   logic [64:0] mp_P;

   mod_exp_ctrl #(.bitLen(64), .countWidth(5), .expLen(64), .TIMEOUT(50)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .M(M), .E(E), .X_bar(X_bar), .R_mod(R_mod),
      .num_words(num_words), .busy(busy), .done(done), .err(err), .result(result),
      .mp_start(mp_start), .mp_A(mp_A), .mp_B(mp_B), .mp_M(mp_M), .mp_num_words(mp_num_words),
      .mp_stop(mp_stop), .mp_P(mp_P)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;
   int rises = 0, dbl = 0, unstable = 0, pulses = 0, cyc = 0;
   bit plus_m = 1'b0, rnd_lat = 1'b0, never_stop = 1'b0;
   int hold_len = 1;

   typedef struct { logic [63:0] res; int prod; } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [63:0] x;
      logic [63:0] e;
      bit          pm;
      bit          rnd;
      logic [63:0] exp_res;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference Montgomery product A*B*2^-64 mod m, optionally left unreduced by +m.
   function automatic logic [64:0] mont_ref(input logic [63:0] a, b, m, input bit pm);
      logic [127:0] r;
      r = ({64'd0, a} * {64'd0, b}) % {64'd0, m};
      for (int i = 0; i < 64; i++) begin
         if (r[0]) r = (r + {64'd0, m}) >> 1;
         else      r = r >> 1;
      end
      mont_ref = pm ? (r[64:0] + {1'b0, m}) : r[64:0];
   endfunction

   function automatic logic [63:0] modexp(input logic [63:0] x, e, m);
      logic [127:0] r, xx, mm;
      r = 128'd1; xx = {64'd0, x}; mm = {64'd0, m};
      for (int i = 63; i >= 0; i--) begin
         r = (r * r) % mm;
         if (e[i]) r = (r * xx) % mm;
      end
      modexp = r[63:0];
   endfunction

   function automatic int prod_count(input logic [63:0] e);
      int pc, top;
      pc = 0; top = -1;
      for (int i = 0; i < 64; i++) begin
         if (e[i]) begin pc++; top = i; end
      end
      prod_count = (e == 64'd0) ? 1 : pc + top + 1 + 1;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   logic done_q = 1'b0;
   always @(posedge clk) begin
      done_q <= done;
      if (done && !done_q) pulses <= pulses + 1;
   end

   // Behavioural mon_prod: latches operands on a rising mp_start, answers after a latency.
   logic start_q, active;
   int lat_cnt, hold_cnt;
   logic [63:0] a_lat, b_lat;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mp_stop <= 1'b0; mp_P <= 65'd0; start_q <= 1'b0; active <= 1'b0;
         lat_cnt <= 0; hold_cnt <= 0; a_lat <= 64'd0; b_lat <= 64'd0;
      end else begin
         start_q <= mp_start;
         if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) mp_stop <= 1'b0;
         end
         if (mp_start && !start_q) begin
            rises <= rises + 1;
            if (active || mp_stop) dbl <= dbl + 1;
            active  <= 1'b1;
            a_lat   <= mp_A;
            b_lat   <= mp_B;
            lat_cnt <= rnd_lat ? int'($urandom_range(40, 1)) : 10;
            mp_P    <= mont_ref(mp_A, mp_B, mp_M, plus_m);
         end else if (active) begin
            if (mp_start && ((mp_A !== a_lat) || (mp_B !== b_lat))) unstable <= unstable + 1;
            if (lat_cnt <= 1) begin
               active <= 1'b0;
               if (!never_stop) begin
                  mp_stop  <= 1'b1;
                  hold_cnt <= hold_len;
               end
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end
      end
   end

   task automatic drive_inputs(input logic [63:0] x, e);
      logic [127:0] t;
      M = M_MOD;
      E = e;
      t = {x, 64'd0} % {64'd0, M_MOD};
      X_bar = t[63:0];
      t = (128'd1 << 64) % {64'd0, M_MOD};
      R_mod = t[63:0];
      num_words = 5'd4;
   endtask

   task automatic run_vec(input logic [63:0] x, e, input bit pm, rnd, input logic [63:0] exp_res,
                          input bit poke_done);
      exp_t ex;
      int r0, d0, u0, p0;
      bit got;
      ex.res = exp_res; ex.prod = prod_count(e);
      sb_q.push_back(ex);
      plus_m = pm; rnd_lat = rnd; hold_len = rnd ? 3 : 1;
      r0 = rises; d0 = dbl; u0 = unstable; p0 = pulses;
      @(negedge clk);
      drive_inputs(x, e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("err_cleared_on_start", err, 1'b0);
      // Inputs change and a second start arrives mid-run; both must be ignored.
      M = 64'd313; E = ~e; X_bar = 64'd0; R_mod = 64'd0; num_words = 5'd9;
      got = 1'b0;
      for (int k = 0; k < 20000 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else start = (k == 3);
      end
      start = 1'b0;
      chk("done_seen", got, 1'b1);
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         ex = sb_q.pop_front();
         chk("result", result, ex.res);
         chk("product_count", rises - r0, ex.prod);
      end
      chk("err_clear", err, 1'b0);
      chk("busy_in_done", busy, 1'b0);
      chk("mp_M_latched", mp_M, M_MOD);
      chk("mp_nw_latched", mp_num_words, 5'd4);
      chk("double_issue", dbl - d0, 0);
      chk("operand_stable", unstable - u0, 0);
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", done, 1'b0);
      chk("done_pulse_count", pulses - p0, 1);
      if (poke_done) begin
         @(negedge clk);
         chk("start_in_done_ignored", busy, 1'b0);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_mp_start"}, mp_start, 1'b0);
      chk({tag, "_result"}, result, 64'd0);
      chk({tag, "_mp_A"}, mp_A, 64'd0);
      chk({tag, "_mp_B"}, mp_B, 64'd0);
      chk({tag, "_mp_M"}, mp_M, 64'd0);
   endtask

   vec_t vecs[10];

   initial begin
      int t0, t1, r0, p0;
      bit got;
      vecs[0] = '{64'd216, 64'd5, 1'b0, 1'b0, 64'd1};
      vecs[1] = '{64'd123, 64'd3, 1'b0, 1'b0, 64'd154};
      vecs[2] = '{64'd77,  64'd0, 1'b0, 1'b0, 64'd1};
      vecs[3] = '{64'd216, 64'd5, 1'b1, 1'b0, 64'd1};
      vecs[4] = '{64'd123, 64'd3, 1'b1, 1'b0, 64'd154};
      vecs[5] = '{64'd77,  64'd0, 1'b1, 1'b0, 64'd1};
      vecs[6] = '{64'd216, 64'd5, 1'b1, 1'b1, 64'd1};
      vecs[7] = '{64'd123, 64'd3, 1'b0, 1'b1, 64'd154};
      vecs[8] = '{64'd200, 64'h8000_0000_0000_0001, 1'b0, 1'b1, modexp(64'd200, 64'h8000_0000_0000_0001, M_MOD)};
      vecs[9] = '{64'd310, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, modexp(64'd310, 64'hFFFF_FFFF_FFFF_FFFF, M_MOD)};

      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i].x, vecs[i].e, vecs[i].pm, vecs[i].rnd, vecs[i].exp_res, i == 1);
      end

      // Stub never answers: timeout must fire TIMEOUT cycles after the first issue.
      never_stop = 1'b1; plus_m = 1'b0; rnd_lat = 1'b0;
      @(negedge clk);
      drive_inputs(64'd216, 64'd5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0; t0 = 0; t1 = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         if (mp_start) begin got = 1'b1; t0 = cyc; end
         else @(negedge clk);
      end
      chk("timeout_issue_seen", got, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; t1 = cyc; end
      end
      chk("timeout_done_seen", got, 1'b1);
      chk("timeout_latency", t1 - t0, 50);
      chk("timeout_err", err, 1'b1);
      chk("timeout_mp_start_low", mp_start, 1'b0);
      chk("timeout_result_kept", result, vecs[9].exp_res);
      @(negedge clk);
      chk("timeout_err_sticky", err, 1'b1);
      chk("timeout_mp_start_stays_low", mp_start, 1'b0);
      never_stop = 1'b0;
      run_vec(64'd123, 64'd3, 1'b0, 1'b0, 64'd154, 1'b0);

      // Asynchronous reset in the middle of a product wait.
      r0 = rises;
      @(negedge clk);
      drive_inputs(64'd216, 64'd5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 500 && (rises - r0) < 3; k++) @(negedge clk);
      chk("reset_run_reached_third", rises - r0, 3);
      repeat (4) @(negedge clk);
      chk("reset_run_in_wait", mp_start, 1'b1);
      p0 = pulses;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("no_done_after_reset", pulses - p0, 0);
      chk("idle_after_reset", busy, 1'b0);
      run_vec(64'd216, 64'd5, 1'b0, 1'b0, 64'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Sequencer that computes X^E mod M by driving one mon_prod instance through left-to-right binary square-and-multiply in the Montgomery domain.
- Inputs are supplied pre-converted: X_bar = X*R mod M, and R_mod = R mod M.
- The block issues each Montgomery product, applies the final conditional subtraction, and finishes with one product by 1 to leave the Montgomery domain.
- It sits between the RSA top-level command logic and mon_prod.

Parameters:
bitLen, 64, operand/modulus width (matches mon_prod)
countWidth, 5, width of num_words (matches mon_prod)
expLen, 64, exponent width
TIMEOUT, 4096, max cycles to wait for mp_stop per product before flagging error

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin exponentiation; sampled in IDLE only
M  in  bitLen  modulus (odd, M < 2^bitLen)
E  in  expLen  exponent
X_bar  in  bitLen  base in Montgomery form (< M)
R_mod  in  bitLen  Montgomery one, R mod M
num_words  in  countWidth  passed through to mon_prod
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when result is valid
err  out  1  sticky timeout flag; cleared by the next accepted start
result  out  bitLen  X^E mod M, held until the next start
mp_start  out  1  mon_prod start (level)
mp_A, mp_B, mp_M  out  bitLen  mon_prod operands
mp_num_words  out  countWidth  mon_prod word count
mp_stop  in  1  mon_prod completion
mp_P  in  bitLen+1  mon_prod product (< 2M)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, err, mp_start = 0; result = 0; mp_A/mp_B/mp_M = 0.
  - Reset mid-operation aborts immediately and produces no done pulse.
- IDLE:
  - On start=1, latch M, E, X_bar, num_words.
  - Set acc=R_mod, err=0, busy=1 -> SCAN.
  - start while busy is ignored.
- SCAN:
  - Bit index i starts at expLen-1.
  - Decrement one bit per cycle until E[i]=1.
  - If E==0, go straight to CONV.
- Per bit i, from the top set bit down to 0:
  - SQ: product(acc, acc).
  - If E[i]=1, follow with MUL: product(acc, X_bar).
  - After bit 0, go to CONV.
- CONV: product(acc, 1). The reduced output goes to result, then DONE.
- Product sub-sequence (ISSUE -> WAIT -> CAPTURE -> GAP):
  - ISSUE:
    - Wait until mp_stop=0.
    - Drive mp_A, mp_B, mp_M, mp_num_words, set mp_start=1, clear the timeout counter.
  - WAIT:
    - mp_start held high and operands held stable.
    - Counter increments each cycle.
    - mp_stop=1 -> CAPTURE.
    - Counter reaching TIMEOUT -> set err, drop mp_start, go to DONE with result unchanged.
  - CAPTURE:
    - acc <= (mp_P >= {1'b0,M}) ? mp_P - M : mp_P[bitLen-1:0], compared at bitLen+1 bits.
    - mp_start <= 0.
  - GAP: at least one cycle with mp_start=0 before the next ISSUE, so mon_prod sees a fresh rising start.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start is not accepted in the DONE cycle.
- Product count: popcount(E) + (index of top set bit + 1) + 1. For E=0 this is 1.
- Simultaneous mp_stop and timeout-terminal-count in the same cycle: mp_stop wins.

Test Plan:
- Bench setup: a behavioural mon_prod stub, P = A*B*R^-1 mod M (optionally +M), R=2^bitLen, fixed latency 10 cycles; the bench precomputes X_bar and R_mod.
- X=216, E=5, M=311:
  - Exactly 6 mp_start rising edges (3 SQ, 2 MUL, 1 CONV).
  - result=1, done pulses once, err=0.
- X=123, E=3, M=311 -> 5 products, result=154.
- E=0, M=311, any X -> 1 product (CONV), result=1.
- Stub returns P+M on every product:
  - Same results as above, proving the conditional subtraction.
  - Stub with random latency 1-40 cycles and mp_stop held high 3 cycles: no double-issue; mp_start low ≥1 cycle between products.
- Stub never asserts mp_stop with TIMEOUT=50:
  - err=1 and done pulse 50 cycles after the first ISSUE.
  - mp_start=0 afterwards; a fresh start clears err.
- rst_n pulsed low mid-WAIT on the X=216 run:
  - All outputs return to reset values asynchronously.
  - No done pulse; a subsequent start completes normally with result=1.
